inv_key_schedule: RTL and testbench

Iterative AES-128 reverse key generator for the decryption datapath. Accepts a 128-bit key and emits the eleven round keys in descending order (round 10 first, round 0 last), one per accepted handshake. The inverse cipher consumes round keys in this order. It is the reverse-direction counterpart of the forward key expansion and replaces a 1408-bit key bus with on-the-fly regeneration.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/sub_word.sv | 20 ++
 rtl/inv_key_schedule.sv | 114 +++++++++++
 tb/tb_inv_key_schedule.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, S-box / Rcon lookups and the inv_key_schedule state type.
// INV_KS_FWD_PRELOAD_EN adds the EXPAND state for cipher-key preload.
package aes_pkg;

    localparam int unsigned AES_NR     = 10;
    localparam int unsigned AES_WORD_W = 32;

    // Byte i of the S-box sits at bits 8i..8i+7 (ascending range).
    localparam logic [0:2047] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[{b, 3'b000} +: 8];
    endfunction

    // Valid for rounds 1..10; index 0 is never used by the key schedule.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef INV_KS_FWD_PRELOAD_EN
    typedef enum logic [1:0] {StIdle, StExpand, StEmit} inv_ks_state_e;
`else
    typedef enum logic {StIdle, StEmit} inv_ks_state_e;
`endif

endpackage

// File: rtl/sub_word.sv
// Combinational RotWord followed by SubWord on one 32-bit key-schedule word.
module sub_word
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] w,
    output logic [AES_WORD_W-1:0] y
);

    logic [AES_WORD_W-1:0] rot;

    assign rot = {w[23:0], w[31:24]};

    always_comb begin
        y = '0;
        for (int i = 0; i < 4; i++) begin
            y[8*i +: 8] = sbox(rot[8*i +: 8]);
        end
    end

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 reverse key generator: emits round keys 10 down to 0.
// INV_KS_FWD_PRELOAD_EN: key_in is the cipher key and is expanded forward first.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [0:127] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    inv_ks_state_e state;

    logic [31:0] w0, w1, w2, w3;
    assign w0 = rk_out[0:31];
    assign w1 = rk_out[32:63];
    assign w2 = rk_out[64:95];
    assign w3 = rk_out[96:127];

    // Reverse step: rebuild w4r-1 first, it feeds the S-box for w4r-4.
    logic [31:0]  inv_t, inv_sw;
    logic [0:127] inv_key;

    assign inv_t = w3 ^ w2;

    sub_word u_inv_sw (
        .w (inv_t),
        .y (inv_sw)
    );

    assign inv_key = {w0 ^ inv_sw ^ {rcon(rk_round), 24'h0}, w1 ^ w0, w2 ^ w1, inv_t};

`ifdef INV_KS_FWD_PRELOAD_EN
    // Forward step: rk_round counts completed rounds, so this forms round rk_round+1.
    logic [31:0]  fwd_sw, f0, f1, f2, f3;
    logic [0:127] fwd_key;

    sub_word u_fwd_sw (
        .w (w3),
        .y (fwd_sw)
    );

    assign f0      = w0 ^ fwd_sw ^ {rcon(rk_round + 4'd1), 24'h0};
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            rk_round  <= 4'd0;
            rk_out    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (key_valid && key_ready) begin
                        rk_out    <= key_in;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef INV_KS_FWD_PRELOAD_EN
                        state     <= StExpand;
                        rk_round  <= 4'd0;
`else
                        state     <= StEmit;
                        rk_round  <= 4'(NR);
                        rk_valid  <= 1'b1;
`endif
                    end
                end
`ifdef INV_KS_FWD_PRELOAD_EN
                StExpand: begin
                    rk_out <= fwd_key;
                    if (rk_round == 4'(NR - 1)) begin
                        state    <= StEmit;
                        rk_round <= 4'(NR);
                        rk_valid <= 1'b1;
                    end else begin
                        rk_round <= rk_round + 4'd1;
                    end
                end
`endif
                StEmit: begin
                    if (rk_ready) begin
                        if (rk_round == 4'd0) begin
                            state     <= StIdle;
                            rk_valid  <= 1'b0;
                            busy      <= 1'b0;
                            key_ready <= 1'b1;
                        end else begin
                            rk_out   <= inv_key;
                            rk_round <= rk_round - 4'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule using the FIPS-197 A.1 key expansion.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:127] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [131:0] sb[$];

    // FIPS-197 A.1 round keys, index = round number.
    localparam logic [127:0] RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

`ifdef INV_KS_FWD_PRELOAD_EN
    localparam int LAT = 11;
    localparam int LOAD_IDX = 0;
`else
    localparam int LAT = 1;
    localparam int LOAD_IDX = 10;
`endif

    inv_key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic push_seq();
        for (int r = 10; r >= 0; r--) sb.push_back({4'(r), RK[r]});
    endtask

    // Called at a negedge; leaves at the negedge after the accept edge.
    task automatic load(input logic [127:0] k);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: key_ready=%b required 1", key_ready);
        end
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 1;
        while (!rk_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LAT || rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: cycles=%0d rk_valid=%b required %0d/1", n, rk_valid, LAT);
        end
    endtask

    task automatic drain(input bit rand_ready, output int cycles);
        logic [131:0] exp_v, held;
        bit stalled = 1'b0;
        cycles = 0;
        while (sb.size() != 0 && cycles < 300) begin
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rk_valid) begin
                if (stalled) begin
                    checks++;
                    if ({rk_round, rk_out} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got %h required %h", {rk_round, rk_out}, held);
                    end
                end
                if (rk_ready) begin
                    exp_v = sb.pop_front();
                    checks++;
                    if ({rk_round, rk_out} !== exp_v) begin
                        errors++;
                        $display("FAIL round_key: got %h required %h", {rk_round, rk_out}, exp_v);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {rk_round, rk_out};
                end
            end
            cycles++;
            @(negedge clk);
        end
        rk_ready = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d keys outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: key_ready=%b rk_valid=%b busy=%b required 1/0/0",
                     name, key_ready, rk_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_ctrl");
        checks++;
        if (rk_round !== 4'd0 || rk_out !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: rk_round=%0d rk_out=%h required 0/0", rk_round, rk_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int cyc;
        load(RK[LOAD_IDX]);
        checks++;
        if (busy !== 1'b1 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_load: busy=%b key_ready=%b required 1/0", busy, key_ready);
        end
        wait_valid();
        push_seq();
        drain(1'b0, cyc);
        checks++;
        if (cyc != 11) begin
            errors++;
            $display("FAIL throughput: cycles=%0d required 11", cyc);
        end
        check_idle("idle_after_round0");
    endtask

    task automatic test_backpressure();
        int cyc;
        load(RK[LOAD_IDX]);
        wait_valid();
        push_seq();
        drain(1'b1, cyc);
        check_idle("idle_after_backpressure");
    endtask

    task automatic test_ignore_key_valid();
        int cyc;
        load(RK[LOAD_IDX]);
        wait_valid();
        push_seq();
        key_in    = 128'h00112233445566778899aabbccddeeff;
        key_valid = 1'b1;
        drain(1'b1, cyc);
        key_valid = 1'b0;
        @(negedge clk);
        check_idle("idle_after_ignored_key");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit found = 1'b0;
        load(RK[LOAD_IDX]);
        wait_valid();
        rk_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rk_round == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_round5: rk_round=%0d required 5", rk_round);
        end
        rk_ready = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset_mid_emit");
        checks++;
        if (rk_round !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_round: rk_round=%0d required 0", rk_round);
        end
        load(RK[LOAD_IDX]);
        wait_valid();
        push_seq();
        drain(1'b0, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        load(RK[LOAD_IDX]);
        wait_valid();
        push_seq();
        drain(1'b0, cyc);
        load(RK[LOAD_IDX]);
        wait_valid();
        push_seq();
        drain(1'b0, cyc);
        check_idle("idle_after_back_to_back");
    endtask

    initial begin
        test_reset();
        test_fips();
        test_backpressure();
        test_ignore_key_valid();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
